// File: rtl/btb_pkg.sv
// Shared helpers for the branch-target-buffer predictor: saturating
// direction-counter arithmetic carried at a fixed maximum width.
package btb_pkg;

    // Widest direction counter the helpers support; callers pass their own width.
    localparam int unsigned CTR_MAX = 16;

    typedef logic [CTR_MAX-1:0] ctr_t;

    function automatic ctr_t ctr_top(input int unsigned bits);
        return (ctr_t'(1'b1) << bits) - ctr_t'(1'b1);
    endfunction

    function automatic ctr_t sat_inc(input ctr_t c, input int unsigned bits);
        return (c >= ctr_top(bits)) ? c : c + ctr_t'(1'b1);
    endfunction

    function automatic ctr_t sat_dec(input ctr_t c);
        return (c == ctr_t'(1'b0)) ? c : c - ctr_t'(1'b1);
    endfunction

    // Weakly taken: MSB set, all lower bits clear.
    function automatic ctr_t weak_taken(input int unsigned bits);
        return ctr_t'(1'b1) << (bits - 1);
    endfunction

endpackage

// File: rtl/btb_predictor_q_if.sv
// Fetch/resolve bundle between the pipeline (master) and the predictor (slave).
interface btb_predictor_q_if #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned CNT_BITS = 16
);
    logic                fetch_valid;
    logic [XLEN-1:0]     fetch_pc;
    logic                fetch_ready;
    logic                pred_taken;
    logic [XLEN-1:0]     pred_pc;
    logic                res_valid;
    logic                res_is_branch;
    logic                res_taken;
    logic [XLEN-1:0]     res_target;
    logic                flush;
    logic [XLEN-1:0]     redirect_pc;
    logic                res_err;
    logic [CNT_BITS-1:0] mispred_cnt;

    modport master (
        output fetch_valid, fetch_pc, res_valid, res_is_branch, res_taken, res_target,
        input  fetch_ready, pred_taken, pred_pc, flush, redirect_pc, res_err, mispred_cnt
    );

    modport slave (
        input  fetch_valid, fetch_pc, res_valid, res_is_branch, res_taken, res_target,
        output fetch_ready, pred_taken, pred_pc, flush, redirect_pc, res_err, mispred_cnt
    );
endinterface

// File: rtl/btb_predictor_q_pred_fifo.sv
// In-flight prediction queue: circular buffer with occupancy count and a
// synchronous clear that overrides any same-cycle push or pop.
module pred_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 65
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW-1:0]    rd_ptr_r;
    logic [AW-1:0]    wr_ptr_r;
    logic [AW:0]      count_r;
    logic [AW:0]      count_next_s;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             push_ok_s;
    logic             pop_ok_s;

    assign empty     = (count_r == '0);
    assign full      = (count_r == (AW+1)'(DEPTH));
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign pop_data  = mem_r[rd_ptr_r];

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_next_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_next_s = count_r + (AW+1)'(1);
            2'b01:   count_next_s = count_r - (AW+1)'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else if (clear) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            count_r <= count_next_s;
        end
    end

    // Payload storage; contents are only meaningful between push and pop.
    always_ff @(posedge clk) begin
        if (push_ok_s && !clear) mem_r[wr_ptr_r] <= push_data;
    end

endmodule

// File: rtl/btb_predictor_q.sv
// Tagged BTB with saturating direction counters; each fetch prediction is
// queued and checked against the pipeline's in-order resolve stream.
module btb_predictor_q
    import btb_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned ENTRIES  = 128,
    parameter int unsigned CTR_BITS = 2,
    parameter int unsigned QDEPTH   = 4,
    parameter int unsigned CNT_BITS = 16
) (
    input logic              clk,
    input logic              rst_n,
    btb_predictor_q_if.slave bus
);
    localparam int unsigned IDX   = $clog2(ENTRIES);
    localparam int unsigned TAG_W = XLEN - IDX - 2;

    typedef struct packed {
        logic                valid;
        logic [TAG_W-1:0]    tag;
        logic [XLEN-1:0]     target;
        logic [CTR_BITS-1:0] ctr;
    } entry_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            pred_taken;
        logic [XLEN-1:0] pred_pc;
    } qent_t;

    logic [ENTRIES-1:0]  valid_r;
    logic [TAG_W-1:0]    tag_r    [ENTRIES];
    logic [XLEN-1:0]     target_r [ENTRIES];
    logic [CTR_BITS-1:0] ctr_r    [ENTRIES];

    logic [IDX-1:0]      f_idx_s;
    logic [TAG_W-1:0]    f_tag_s;
    entry_t              f_ent_s;
    logic                f_hit_s;
    logic                pred_taken_s;
    logic [XLEN-1:0]     pred_pc_s;

    qent_t               push_ent_s;
    qent_t               head_s;
    logic                push_s;
    logic                pop_s;
    logic                empty_s;
    logic                full_s;

    logic                actual_taken_s;
    logic [XLEN-1:0]     actual_next_s;
    logic                mispred_s;

    logic [IDX-1:0]      u_idx_s;
    logic [TAG_W-1:0]    u_tag_s;
    entry_t              u_ent_s;
    logic                u_hit_s;
    logic                wr_en_s;
    logic                alloc_s;
    logic [TAG_W-1:0]    wr_tag_s;
    logic [XLEN-1:0]     wr_target_s;
    logic [CTR_BITS-1:0] wr_ctr_s;

    logic                flush_r;
    logic [XLEN-1:0]     redirect_pc_r;
    logic                res_err_r;
    logic [CNT_BITS-1:0] mispred_cnt_r;

    assign f_idx_s = bus.fetch_pc[IDX+1:2];
    assign f_tag_s = bus.fetch_pc[XLEN-1:IDX+2];

    // Fetch-side lookup; reads the array before any same-cycle update lands.
    always_comb begin
        f_ent_s      = '{valid_r[f_idx_s], tag_r[f_idx_s], target_r[f_idx_s], ctr_r[f_idx_s]};
        f_hit_s      = f_ent_s.valid && (f_ent_s.tag == f_tag_s);
        pred_taken_s = f_hit_s && f_ent_s.ctr[CTR_BITS-1];
        if (pred_taken_s) begin
            pred_pc_s = f_ent_s.target;
        end else begin
            pred_pc_s = bus.fetch_pc + XLEN'(4);
        end
    end

    assign push_s     = bus.fetch_valid && !full_s;
    assign pop_s      = bus.res_valid && !empty_s;
    assign push_ent_s = '{bus.fetch_pc, pred_taken_s, pred_pc_s};

    pred_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH ($bits(qent_t))
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (mispred_s),
        .push      (push_s),
        .push_data (push_ent_s),
        .pop       (pop_s),
        .pop_data  (head_s),
        .empty     (empty_s),
        .full      (full_s)
    );

    // Compare the oldest prediction with what actually happened. Two
    // fall-through paths always agree, so only a taken side can disagree.
    always_comb begin
        actual_taken_s = bus.res_is_branch && bus.res_taken;
        if (actual_taken_s) begin
            actual_next_s = bus.res_target;
        end else begin
            actual_next_s = head_s.pc + XLEN'(4);
        end
        mispred_s = pop_s && (head_s.pred_taken || actual_taken_s)
                    && (actual_next_s != head_s.pred_pc);
    end

    assign u_idx_s = head_s.pc[IDX+1:2];
    assign u_tag_s = head_s.pc[XLEN-1:IDX+2];

    // Resolve-side training of the entry addressed by the head PC.
    always_comb begin
        u_ent_s     = '{valid_r[u_idx_s], tag_r[u_idx_s], target_r[u_idx_s], ctr_r[u_idx_s]};
        u_hit_s     = u_ent_s.valid && (u_ent_s.tag == u_tag_s);
        wr_en_s     = 1'b0;
        alloc_s     = 1'b0;
        wr_tag_s    = u_ent_s.tag;
        wr_target_s = u_ent_s.target;
        wr_ctr_s    = u_ent_s.ctr;
        if (pop_s && bus.res_is_branch) begin
            if (u_hit_s) begin
                wr_en_s = 1'b1;
                if (bus.res_taken) begin
                    wr_ctr_s    = CTR_BITS'(sat_inc(ctr_t'(u_ent_s.ctr), CTR_BITS));
                    wr_target_s = bus.res_target;
                end else begin
                    wr_ctr_s    = CTR_BITS'(sat_dec(ctr_t'(u_ent_s.ctr)));
                end
            end else if (bus.res_taken) begin
                wr_en_s     = 1'b1;
                alloc_s     = 1'b1;
                wr_tag_s    = u_tag_s;
                wr_target_s = bus.res_target;
                wr_ctr_s    = CTR_BITS'(weak_taken(CTR_BITS));
            end else begin
                wr_en_s = 1'b0;
            end
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Valid bits are the only array state that needs a reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= '0;
        end else if (alloc_s) begin
            valid_r[u_idx_s] <= 1'b1;
        end
    end

    // Tag, target and counter payload.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            tag_r[u_idx_s]    <= wr_tag_s;
            target_r[u_idx_s] <= wr_target_s;
            ctr_r[u_idx_s]    <= wr_ctr_s;
        end
    end

    // Registered mispredict, error and statistics outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_r       <= 1'b0;
            redirect_pc_r <= '0;
            res_err_r     <= 1'b0;
            mispred_cnt_r <= '0;
        end else begin
            flush_r   <= mispred_s;
            res_err_r <= bus.res_valid && empty_s;
            if (mispred_s) begin
                redirect_pc_r <= actual_next_s;
                if (mispred_cnt_r != '1) mispred_cnt_r <= mispred_cnt_r + CNT_BITS'(1);
            end
        end
    end

    assign bus.fetch_ready = !full_s;
    assign bus.pred_taken  = pred_taken_s;
    assign bus.pred_pc     = pred_pc_s;
    assign bus.flush       = flush_r;
    assign bus.redirect_pc = redirect_pc_r;
    assign bus.res_err     = res_err_r;
    assign bus.mispred_cnt = mispred_cnt_r;

endmodule

// File: tb/tb_btb_predictor_q.sv
// Directed bench for btb_predictor_q: one table of per-cycle vectors plus
// hand-written reset sequences; a CNT_BITS=2 twin shadows the same stimulus.
module tb_btb_predictor_q;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    btb_predictor_q_if #(.XLEN(32), .CNT_BITS(16)) bus ();
    btb_predictor_q_if #(.XLEN(32), .CNT_BITS(2))  bus2 ();

    btb_predictor_q #(.XLEN(32), .ENTRIES(128), .CTR_BITS(2), .QDEPTH(4), .CNT_BITS(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave));

    btb_predictor_q #(.XLEN(32), .ENTRIES(128), .CTR_BITS(2), .QDEPTH(4), .CNT_BITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2.slave));

    assign bus2.fetch_valid   = bus.fetch_valid;
    assign bus2.fetch_pc      = bus.fetch_pc;
    assign bus2.res_valid     = bus.res_valid;
    assign bus2.res_is_branch = bus.res_is_branch;
    assign bus2.res_taken     = bus.res_taken;
    assign bus2.res_target    = bus.res_target;

    typedef struct {
        logic        fv;
        logic [31:0] fpc;
        logic        rv;
        logic        br;
        logic        tk;
        logic [31:0] tgt;
        logic        e_taken;
        logic [31:0] e_pc;
        logic        e_rdy;
        logic        e_flush;
        logic [31:0] e_redir;
        logic        e_err;
        logic [15:0] e_cnt;
        logic [1:0]  e_cnt2;
    } vec_t;

    localparam int NVEC = 25;
    vec_t vecs [NVEC];
    int n_checks = 0;
    int n_pass   = 0;

    function automatic vec_t mk(input logic fv, input logic [31:0] fpc, input logic rv,
                                input logic br, input logic tk, input logic [31:0] tgt,
                                input logic e_taken, input logic [31:0] e_pc, input logic e_rdy,
                                input logic e_flush, input logic [31:0] e_redir, input logic e_err,
                                input logic [15:0] e_cnt, input logic [1:0] e_cnt2);
        vec_t v;
        v = '{fv, fpc, rv, br, tk, tgt, e_taken, e_pc, e_rdy, e_flush, e_redir, e_err, e_cnt, e_cnt2};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic drive(input logic fv, input logic [31:0] fpc, input logic rv,
                         input logic br, input logic tk, input logic [31:0] tgt);
        bus.fetch_valid   = fv;
        bus.fetch_pc      = fpc;
        bus.res_valid     = rv;
        bus.res_is_branch = br;
        bus.res_taken     = tk;
        bus.res_target    = tgt;
    endtask

    task automatic run_vec(input int i, input vec_t v);
        @(negedge clk);
        drive(v.fv, v.fpc, v.rv, v.br, v.tk, v.tgt);
        #1;
        chk($sformatf("v%0d.pred_taken", i), 32'(bus.pred_taken), 32'(v.e_taken));
        chk($sformatf("v%0d.pred_pc", i), bus.pred_pc, v.e_pc);
        chk($sformatf("v%0d.fetch_ready", i), 32'(bus.fetch_ready), 32'(v.e_rdy));
        @(posedge clk);
        #1;
        chk($sformatf("v%0d.flush", i), 32'(bus.flush), 32'(v.e_flush));
        chk($sformatf("v%0d.res_err", i), 32'(bus.res_err), 32'(v.e_err));
        chk($sformatf("v%0d.mispred_cnt", i), 32'(bus.mispred_cnt), 32'(v.e_cnt));
        chk($sformatf("v%0d.mispred_cnt2", i), 32'(bus2.mispred_cnt), 32'(v.e_cnt2));
        if (v.e_flush) chk($sformatf("v%0d.redirect_pc", i), bus.redirect_pc, v.e_redir);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time exhausted, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //                fv    fpc           rv    br    tk    tgt           taken pc            rdy   flush redir         err   cnt     cnt2
        vecs[0]  = mk(1'b1, 32'h10,        1'b0, 1'b0, 1'b0, 32'h0,      1'b0, 32'h14,       1'b1, 1'b0, 32'h0,      1'b0, 16'd0, 2'd0);
        vecs[1]  = mk(1'b0, 32'h10,        1'b1, 1'b1, 1'b1, 32'h40,     1'b0, 32'h14,       1'b1, 1'b1, 32'h40,     1'b0, 16'd1, 2'd1);
        vecs[2]  = mk(1'b1, 32'h10,        1'b0, 1'b0, 1'b0, 32'h0,      1'b1, 32'h40,       1'b1, 1'b0, 32'h0,      1'b0, 16'd1, 2'd1);
        vecs[3]  = mk(1'b1, 32'h10,        1'b1, 1'b1, 1'b1, 32'h40,     1'b1, 32'h40,       1'b1, 1'b0, 32'h0,      1'b0, 16'd1, 2'd1);
        vecs[4]  = mk(1'b1, 32'h10,        1'b1, 1'b1, 1'b1, 32'h40,     1'b1, 32'h40,       1'b1, 1'b0, 32'h0,      1'b0, 16'd1, 2'd1);
        vecs[5]  = mk(1'b1, 32'h10,        1'b1, 1'b1, 1'b1, 32'h40,     1'b1, 32'h40,       1'b1, 1'b0, 32'h0,      1'b0, 16'd1, 2'd1);
        vecs[6]  = mk(1'b0, 32'h10,        1'b1, 1'b1, 1'b0, 32'h0,      1'b1, 32'h40,       1'b1, 1'b1, 32'h14,     1'b0, 16'd2, 2'd2);
        vecs[7]  = mk(1'b1, 32'h10,        1'b0, 1'b0, 1'b0, 32'h0,      1'b1, 32'h40,       1'b1, 1'b0, 32'h0,      1'b0, 16'd2, 2'd2);
        vecs[8]  = mk(1'b0, 32'h10,        1'b1, 1'b1, 1'b0, 32'h0,      1'b1, 32'h40,       1'b1, 1'b1, 32'h14,     1'b0, 16'd3, 2'd3);
        vecs[9]  = mk(1'b1, 32'h10,        1'b0, 1'b0, 1'b0, 32'h0,      1'b0, 32'h14,       1'b1, 1'b0, 32'h0,      1'b0, 16'd3, 2'd3);
        vecs[10] = mk(1'b0, 32'h10,        1'b1, 1'b0, 1'b0, 32'h0,      1'b0, 32'h14,       1'b1, 1'b0, 32'h0,      1'b0, 16'd3, 2'd3);
        vecs[11] = mk(1'b1, 32'h210,       1'b0, 1'b0, 1'b0, 32'h0,      1'b0, 32'h214,      1'b1, 1'b0, 32'h0,      1'b0, 16'd3, 2'd3);
        vecs[12] = mk(1'b0, 32'h210,       1'b1, 1'b1, 1'b1, 32'h300,    1'b0, 32'h214,      1'b1, 1'b1, 32'h300,    1'b0, 16'd4, 2'd3);
        vecs[13] = mk(1'b0, 32'h210,       1'b0, 1'b0, 1'b0, 32'h0,      1'b1, 32'h300,      1'b1, 1'b0, 32'h0,      1'b0, 16'd4, 2'd3);
        vecs[14] = mk(1'b0, 32'h10,        1'b0, 1'b0, 1'b0, 32'h0,      1'b0, 32'h14,       1'b1, 1'b0, 32'h0,      1'b0, 16'd4, 2'd3);
        vecs[15] = mk(1'b1, 32'h100,       1'b0, 1'b0, 1'b0, 32'h0,      1'b0, 32'h104,      1'b1, 1'b0, 32'h0,      1'b0, 16'd4, 2'd3);
        vecs[16] = mk(1'b1, 32'h104,       1'b0, 1'b0, 1'b0, 32'h0,      1'b0, 32'h108,      1'b1, 1'b0, 32'h0,      1'b0, 16'd4, 2'd3);
        vecs[17] = mk(1'b1, 32'h108,       1'b0, 1'b0, 1'b0, 32'h0,      1'b0, 32'h10c,      1'b1, 1'b0, 32'h0,      1'b0, 16'd4, 2'd3);
        vecs[18] = mk(1'b1, 32'h10c,       1'b0, 1'b0, 1'b0, 32'h0,      1'b0, 32'h110,      1'b1, 1'b0, 32'h0,      1'b0, 16'd4, 2'd3);
        vecs[19] = mk(1'b1, 32'h110,       1'b0, 1'b0, 1'b0, 32'h0,      1'b0, 32'h114,      1'b0, 1'b0, 32'h0,      1'b0, 16'd4, 2'd3);
        vecs[20] = mk(1'b1, 32'h110,       1'b1, 1'b0, 1'b0, 32'h0,      1'b0, 32'h114,      1'b0, 1'b0, 32'h0,      1'b0, 16'd4, 2'd3);
        vecs[21] = mk(1'b1, 32'h110,       1'b1, 1'b1, 1'b1, 32'h500,    1'b0, 32'h114,      1'b1, 1'b1, 32'h500,    1'b0, 16'd5, 2'd3);
        vecs[22] = mk(1'b0, 32'h110,       1'b1, 1'b1, 1'b1, 32'h900,    1'b0, 32'h114,      1'b1, 1'b0, 32'h0,      1'b1, 16'd5, 2'd3);
        vecs[23] = mk(1'b0, 32'h104,       1'b0, 1'b0, 1'b0, 32'h0,      1'b1, 32'h500,      1'b1, 1'b0, 32'h0,      1'b0, 16'd5, 2'd3);
        vecs[24] = mk(1'b0, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0,        1'b1, 1'b0, 32'h0,      1'b0, 16'd5, 2'd3);

        drive(1'b0, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0);
        #12;
        chk("rst.fetch_ready", 32'(bus.fetch_ready), 32'h1);
        chk("rst.pred_pc", bus.pred_pc, 32'h14);
        chk("rst.pred_taken", 32'(bus.pred_taken), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst.flush", 32'(bus.flush), 32'h0);
        chk("rst.res_err", 32'(bus.res_err), 32'h0);
        chk("rst.redirect_pc", bus.redirect_pc, 32'h0);
        chk("rst.mispred_cnt", 32'(bus.mispred_cnt), 32'h0);

        for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);

        // Reset lands during a mispredicting resolve: the flush must never appear.
        @(negedge clk);
        drive(1'b1, 32'h700, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        drive(1'b0, 32'h104, 1'b1, 1'b1, 1'b1, 32'h800);
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst.flush", 32'(bus.flush), 32'h0);
        chk("mid_rst.mispred_cnt", 32'(bus.mispred_cnt), 32'h0);
        chk("mid_rst.mispred_cnt2", 32'(bus2.mispred_cnt), 32'h0);
        chk("mid_rst.redirect_pc", bus.redirect_pc, 32'h0);
        chk("mid_rst.fetch_ready", 32'(bus.fetch_ready), 32'h1);
        chk("mid_rst.pred_pc", bus.pred_pc, 32'h108);
        chk("mid_rst.pred_taken", 32'(bus.pred_taken), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 32'h104, 1'b0, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        chk("post_rst.flush", 32'(bus.flush), 32'h0);
        chk("post_rst.res_err", 32'(bus.res_err), 32'h0);

        // Queue must be empty after reset, so a resolve now is an error.
        @(negedge clk);
        drive(1'b0, 32'h104, 1'b1, 1'b1, 1'b1, 32'h800);
        @(posedge clk);
        #1;
        chk("post_rst_empty.res_err", 32'(bus.res_err), 32'h1);
        chk("post_rst_empty.flush", 32'(bus.flush), 32'h0);
        @(negedge clk);
        drive(1'b0, 32'h104, 1'b0, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        chk("err_pulse_end.res_err", 32'(bus.res_err), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
